out_frame_arbiter: RTL and testbench



---
 rtl/ofa_pkg.sv | 22 ++
 rtl/out_frame_arbiter_if.sv | 31 +++
 rtl/out_frame_arbiter_rr_pick.sv | 44 ++++
 rtl/out_frame_arbiter.sv | 135 +++++++++++++
 tb/tb_out_frame_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ofa_pkg.sv
// Shared definitions for out_frame_arbiter.
//   state_e        : arbiter FSM encodings
//   NUM_SRC_MAX    : largest supported source count
//   idx_w()        : width of a source index for a given source count
package ofa_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_FORWARD = 2'd2,
    S_GAP     = 2'd3
  } state_e;

  localparam int NUM_SRC_MAX = 8;
  localparam int IDX_W_MAX   = $clog2(NUM_SRC_MAX);

  // Index width for n sources; never less than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_frame_arbiter_if.sv
// Bus bundle between the message generators, the arbiter and bus_interface.
//   src_req/src_data/src_data_latch/src_frame_valid : per-source request and frame
//   src_gnt                                         : one-hot grant back to sources
//   out_frame_*                                     : merged frame towards bus_interface
//   timeout_pulse                                   : grant revoked by timeout
// slave  = arbiter side, master = sources / bus_interface side.
interface out_frame_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0]   src_req;
  logic [NUM_SRC-1:0]   src_gnt;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_data_latch;
  logic [NUM_SRC-1:0]   src_frame_valid;
  logic [7:0]           out_frame_data;
  logic                 out_frame_data_latch;
  logic                 out_frame_valid;
  logic                 timeout_pulse;

  modport slave (
    input  src_req, src_data, src_data_latch, src_frame_valid,
    output src_gnt, out_frame_data, out_frame_data_latch, out_frame_valid,
           timeout_pulse
  );

  modport master (
    output src_req, src_data, src_data_latch, src_frame_valid,
    input  src_gnt, out_frame_data, out_frame_data_latch, out_frame_valid,
           timeout_pulse
  );
endinterface

// File: rtl/out_frame_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i     : request vector
//   ptr_i     : search start position
//   win_oh_o  : one-hot winner (0 when no request)
//   win_idx_o : winner index
//   any_req_o : at least one request present
module rr_pick
  import ofa_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] win_oh_o,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               any_req_o
);

  int             j;
  logic [IDX_W-1:0] jj;
  logic           found;

  // Walk ptr, ptr+1, ... wrapping at NUM_SRC; first set bit wins.
  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    any_req_o = |req_i;
    found     = 1'b0;
    j         = 0;
    jj        = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      jj = IDX_W'(j);
      if (!found && req_i[jj]) begin
        found        = 1'b1;
        win_idx_o    = jj;
        win_oh_o[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_frame_arbiter.sv
// out_frame_arbiter: round-robin, frame-atomic sharing of the outbound frame
// path of bus_interface between NUM_SRC message generators.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : out_frame_arbiter_if.slave (source requests/frames in, grant and
//           merged frame out, timeout pulse out); all outputs registered.
module out_frame_arbiter
  import ofa_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int GRANT_TIMEOUT = 64,
  parameter int TMR_W         = 7,
  parameter int GAP_CYCLES    = 1
) (
  input  logic                clk,
  input  logic                reset,
  out_frame_arbiter_if.slave  bus
);

  localparam int IDX_W = idx_w(NUM_SRC);

  state_e               state_q;
  logic [NUM_SRC-1:0]   gnt_q;
  logic [IDX_W-1:0]     g_idx_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [TMR_W-1:0]     timer_q;
  logic [7:0]           out_d_q;
  logic                 out_l_q;
  logic                 out_v_q;
  logic                 timeout_q;

  logic [NUM_SRC-1:0]   win_oh;
  logic [IDX_W-1:0]     win_idx;
  logic                 any_req;
  logic [IDX_W-1:0]     ptr_d;

  logic [NUM_SRC-1:0][7:0] data_v;
  logic                 sel_req, sel_fv, sel_latch;
  logic [7:0]           sel_data;

  rr_pick #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_pick (
    .req_i     (bus.src_req),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .any_req_o (any_req)
  );

  // Only the granted source's inputs are ever looked at.
  assign data_v    = bus.src_data;
  assign sel_req   = bus.src_req[g_idx_q];
  assign sel_fv    = bus.src_frame_valid[g_idx_q];
  assign sel_latch = bus.src_data_latch[g_idx_q];
  assign sel_data  = data_v[g_idx_q];

  assign ptr_d = (win_idx == IDX_W'(NUM_SRC - 1)) ? '0 : win_idx + IDX_W'(1);

  // timer_q counts WAIT cycles against the grant timeout and is reused to
  // count idle cycles in GAP; the two uses never overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      g_idx_q   <= '0;
      ptr_q     <= '0;
      timer_q   <= '0;
      out_d_q   <= '0;
      out_l_q   <= 1'b0;
      out_v_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      out_d_q   <= '0;
      out_l_q   <= 1'b0;
      out_v_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            gnt_q   <= win_oh;
            g_idx_q <= win_idx;
            ptr_q   <= ptr_d;
            timer_q <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sel_fv) begin
            // First byte may arrive with the rising envelope; forward it now.
            out_v_q <= 1'b1;
            out_d_q <= sel_data;
            out_l_q <= sel_latch;
            state_q <= S_FORWARD;
          end else if (!sel_req) begin
            gnt_q   <= '0;
            timer_q <= '0;
            state_q <= S_GAP;
          end else if (timer_q == TMR_W'(GRANT_TIMEOUT - 1)) begin
            gnt_q     <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b1;
            state_q   <= S_GAP;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_FORWARD: begin
          out_v_q <= sel_fv;
          out_d_q <= sel_data;
          out_l_q <= sel_latch & sel_fv;
          if (!sel_fv) begin
            gnt_q   <= '0;
            timer_q <= '0;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (timer_q == TMR_W'(GAP_CYCLES - 1)) begin
            timer_q <= '0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.src_gnt              = gnt_q;
  assign bus.out_frame_data       = out_d_q;
  assign bus.out_frame_data_latch = out_l_q;
  assign bus.out_frame_valid      = out_v_q;
  assign bus.timeout_pulse        = timeout_q;

endmodule

// File: tb/tb_out_frame_arbiter.sv
module tb_out_frame_arbiter;

  localparam int NS = 4;

  logic clk = 1'b0;
  logic reset;

  out_frame_arbiter_if #(.NUM_SRC(NS)) ifc ();

  out_frame_arbiter #(
    .NUM_SRC(NS), .GRANT_TIMEOUT(64), .TMR_W(7), .GAP_CYCLES(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  fv;
    logic [3:0]  lat;
    logic [31:0] data;
    logic [3:0]  e_gnt;
    logic        e_v;
    logic        e_l;
    logic [7:0]  e_d;
    logic        e_to;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.src_req         = '0;
    ifc.src_frame_valid = '0;
    ifc.src_data_latch  = '0;
    ifc.src_data        = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] req, fv, lat, input logic [31:0] data,
                              input logic [3:0] g, input logic v, l, input logic [7:0] d,
                              input logic to);
    vec_t r;
    r.req = req; r.fv = fv; r.lat = lat; r.data = data;
    r.e_gnt = g; r.e_v = v; r.e_l = l; r.e_d = d; r.e_to = to;
    return r;
  endfunction

  // Waits for a grant, then the granted source sends nbytes latched bytes
  // {who,k}. Checks the forwarded stream and the closing edge.
  task automatic serve_frame(input int nbytes, input bit keep_req, output int who);
    int n;
    logic [7:0] b;
    n = 0;
    who = -1;
    while (ifc.src_gnt == '0 && n < 10) begin
      tick();
      n++;
    end
    if (ifc.src_gnt == '0) begin
      chk("grant_wait_timeout", 32'(n), 32'd0);
      return;
    end
    for (int i = 0; i < NS; i++) if (ifc.src_gnt[i]) who = i;
    chk("gnt_onehot", 32'($countones(ifc.src_gnt)), 32'd1);
    chk("out_v_low_before_frame", 32'(ifc.out_frame_valid), 32'd0);
    if (!keep_req) ifc.src_req[who] = 1'b0;
    for (int k = 0; k < nbytes; k++) begin
      b = {4'(who), 4'(k)};
      ifc.src_frame_valid[who]  = 1'b1;
      ifc.src_data_latch[who]   = 1'b1;
      ifc.src_data[8*who +: 8]  = b;
      tick();
      chk("fr_v", 32'(ifc.out_frame_valid), 32'd1);
      chk("fr_l", 32'(ifc.out_frame_data_latch), 32'd1);
      chk("fr_d", 32'(ifc.out_frame_data), 32'(b));
    end
    ifc.src_frame_valid[who] = 1'b0;
    ifc.src_data_latch[who]  = 1'b0;
    ifc.src_data[8*who +: 8] = 8'h00;
    tick();
    chk("fr_end_v", 32'(ifc.out_frame_valid), 32'd0);
    chk("fr_end_gnt", 32'(ifc.src_gnt), 32'd0);
  endtask

  initial begin
    int who, n;
    int exp_c[3];
    reset = 1'b1;
    clear_inputs();
    tick();
    // Reset state
    chk("rst_gnt", 32'(ifc.src_gnt), 32'd0);
    chk("rst_v", 32'(ifc.out_frame_valid), 32'd0);
    chk("rst_l", 32'(ifc.out_frame_data_latch), 32'd0);
    chk("rst_d", 32'(ifc.out_frame_data), 32'd0);
    chk("rst_to", 32'(ifc.timeout_pulse), 32'd0);
    tick();
    reset = 1'b0;

    // Single source frame 65,01,AA on src1 (with an unlatched filler byte),
    // then src0 frame with src1 noise and latches while frame_valid is low.
    //           req    fv     lat    data          gnt    v  l  d      to
    vt.push_back(mk(4'h2, 4'h0, 4'h0, 32'h0,        4'h2, 0, 0, 8'h00, 0));
    vt.push_back(mk(4'h0, 4'h2, 4'h2, 32'h0000_6500, 4'h2, 1, 1, 8'h65, 0));
    vt.push_back(mk(4'h0, 4'h2, 4'h0, 32'h0,        4'h2, 1, 0, 8'h00, 0));
    vt.push_back(mk(4'h0, 4'h2, 4'h2, 32'h0000_0100, 4'h2, 1, 1, 8'h01, 0));
    vt.push_back(mk(4'h0, 4'h2, 4'h2, 32'h0000_AA00, 4'h2, 1, 1, 8'hAA, 0));
    vt.push_back(mk(4'h0, 4'h0, 4'h0, 32'h0,        4'h0, 0, 0, 8'h00, 0));
    vt.push_back(mk(4'h0, 4'h0, 4'h0, 32'h0,        4'h0, 0, 0, 8'h00, 0));
    vt.push_back(mk(4'h0, 4'h0, 4'h0, 32'h0,        4'h0, 0, 0, 8'h00, 0));
    vt.push_back(mk(4'h1, 4'h0, 4'h0, 32'h0,        4'h1, 0, 0, 8'h00, 0));
    vt.push_back(mk(4'h1, 4'h2, 4'h3, 32'h0000_2211, 4'h1, 0, 0, 8'h00, 0));
    vt.push_back(mk(4'h0, 4'h1, 4'h3, 32'h0000_4433, 4'h1, 1, 1, 8'h33, 0));
    vt.push_back(mk(4'h0, 4'h3, 4'h2, 32'h0000_6655, 4'h1, 1, 0, 8'h55, 0));
    vt.push_back(mk(4'h0, 4'h3, 4'h3, 32'h0000_8877, 4'h1, 1, 1, 8'h77, 0));
    vt.push_back(mk(4'h0, 4'h2, 4'h3, 32'h0000_9900, 4'h0, 0, 0, 8'h00, 0));
    vt.push_back(mk(4'h0, 4'h0, 4'h0, 32'h0,        4'h0, 0, 0, 8'h00, 0));

    foreach (vt[i]) begin
      ifc.src_req         = vt[i].req;
      ifc.src_frame_valid = vt[i].fv;
      ifc.src_data_latch  = vt[i].lat;
      ifc.src_data        = vt[i].data;
      tick();
      chk($sformatf("vec%0d_gnt", i), 32'(ifc.src_gnt), 32'(vt[i].e_gnt));
      chk($sformatf("vec%0d_v", i), 32'(ifc.out_frame_valid), 32'(vt[i].e_v));
      chk($sformatf("vec%0d_l", i), 32'(ifc.out_frame_data_latch), 32'(vt[i].e_l));
      chk($sformatf("vec%0d_d", i), 32'(ifc.out_frame_data), 32'(vt[i].e_d));
      chk($sformatf("vec%0d_to", i), 32'(ifc.timeout_pulse), 32'(vt[i].e_to));
    end

    // Contention: 0,2,3 together -> grants 0,2,3; pointer wraps back to 0.
    do_reset();
    ifc.src_req = 4'b1101;
    exp_c = '{0, 2, 3};
    for (int f = 0; f < 3; f++) begin
      serve_frame(2, 1'b0, who);
      chk("cont_order", 32'(who), 32'(exp_c[f]));
    end
    ifc.src_req = 4'b1111;
    serve_frame(1, 1'b0, who);
    chk("cont_ptr_wrap", 32'(who), 32'd0);
    ifc.src_req = '0;

    // Fairness: all requesting continuously for 8 frames.
    do_reset();
    ifc.src_req = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      serve_frame(1, 1'b1, who);
      chk("fair_order", 32'(who), 32'(f % 4));
    end
    ifc.src_req = '0;

    // Timeout: src2 granted but silent; src3 pending.
    do_reset();
    ifc.src_req = 4'b1100;
    tick();
    chk("to_gnt2", 32'(ifc.src_gnt), 32'h4);
    n = 0;
    while (ifc.src_gnt == 4'b0100 && n < 200) begin
      n++;
      tick();
      if (ifc.src_gnt == 4'b0100)
        chk("to_no_early_pulse", 32'(ifc.timeout_pulse), 32'd0);
    end
    chk("to_cycles", 32'(n), 32'd64);
    chk("to_pulse", 32'(ifc.timeout_pulse), 32'd1);
    chk("to_gnt_clear", 32'(ifc.src_gnt), 32'd0);
    tick();
    chk("to_pulse_once", 32'(ifc.timeout_pulse), 32'd0);
    tick();
    chk("to_next_gnt3", 32'(ifc.src_gnt), 32'h8);
    ifc.src_req = '0;

    // Withdrawal in WAIT: grant drops, no timeout pulse.
    do_reset();
    ifc.src_req = 4'b0010;
    tick();
    chk("wd_gnt", 32'(ifc.src_gnt), 32'h2);
    ifc.src_req = '0;
    tick();
    chk("wd_gnt_clear", 32'(ifc.src_gnt), 32'd0);
    chk("wd_no_pulse", 32'(ifc.timeout_pulse), 32'd0);

    // Reset mid-frame on the 2nd byte of src0.
    do_reset();
    ifc.src_req = 4'b0001;
    tick();
    chk("rm_gnt", 32'(ifc.src_gnt), 32'h1);
    ifc.src_req = '0;
    ifc.src_frame_valid = 4'b0001;
    ifc.src_data_latch  = 4'b0001;
    ifc.src_data        = 32'h0000_00C1;
    tick();
    chk("rm_v1", 32'(ifc.out_frame_valid), 32'd1);
    ifc.src_data = 32'h0000_00C2;
    reset = 1'b1;
    tick();
    chk("rm_gnt0", 32'(ifc.src_gnt), 32'd0);
    chk("rm_v0", 32'(ifc.out_frame_valid), 32'd0);
    chk("rm_l0", 32'(ifc.out_frame_data_latch), 32'd0);
    chk("rm_to0", 32'(ifc.timeout_pulse), 32'd0);
    reset = 1'b0;
    clear_inputs();
    ifc.src_req = 4'b1001;  // ptr back at 0 picks src0, a stale ptr=1 would pick src3
    tick();
    chk("rm_ptr0", 32'(ifc.src_gnt), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
